// File: rtl/nibble_serial_alu_seq_pkg.sv
// Shared types for the nibble-serial add/subtract sequencer: FSM state encoding
// and operation-select constants.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/nibble_serial_alu_seq_cla.sv
// 4-bit carry-lookahead adder: the single arithmetic slice reused by the
// nibble-serial sequencer on every iteration.
module CLA_4Bit (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_s,
    output logic       o_cout
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Every carry is expanded from generate/propagate, none ripples from the previous one.
    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

    assign o_s    = w_p ^ w_c[3:0];
    assign o_cout = w_c[4];

endmodule

// File: rtl/nibble_serial_alu_seq.sv
// Multi-cycle WIDTH-bit add/subtract that reuses one 4-bit CLA, one nibble per
// cycle LSB first, with valid/ready handshakes on both sides.
module nibble_serial_alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = $clog2(NIB);

    seq_state_t       r_state;
    seq_state_t       w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;

    logic [WIDTH-1:0] w_a_sh;
    logic [WIDTH-1:0] w_b_sh;
    logic [3:0]       w_nib_sum;
    logic             w_nib_cout;
    logic             w_last;
    logic [WIDTH-1:0] w_final_sum;

    assign w_a_sh = r_a >> {r_idx, 2'b00};
    assign w_b_sh = r_b >> {r_idx, 2'b00};
    assign w_last = (r_idx == IDX_W'(NIB - 1));
    // On the last iteration all lower nibbles are already in r_result.
    assign w_final_sum = {w_nib_sum, r_result[WIDTH-5:0]};

    CLA_4Bit u_cla (
        .i_a    (w_a_sh[3:0]),
        .i_b    (w_b_sh[3:0]),
        .i_cin  (r_carry),
        .o_s    (w_nib_sum),
        .o_cout (w_nib_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = RUN;
            end
            RUN: begin
                if (w_last) w_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            ovf      <= 1'b0;
            zero     <= 1'b0;
        end else if (r_state == IDLE) begin
            if (in_valid) begin
                // Subtract is A + ~B + 1; the +1 enters through the initial carry.
                r_a     <= a;
                r_b     <= (sub == OP_SUB) ? ~b : b;
                r_carry <= (sub == OP_SUB);
                r_idx   <= '0;
            end
        end else if (r_state == RUN) begin
            for (int n = 0; n < NIB; n++) begin
                if (r_idx == IDX_W'(n)) r_result[4*n +: 4] <= w_nib_sum;
            end
            r_carry <= w_nib_cout;
            if (w_last) begin
                sum  <= w_final_sum;
                cout <= w_nib_cout;
                ovf  <= (r_a[WIDTH-1] ~^ r_b[WIDTH-1]) & (w_final_sum[WIDTH-1] ^ r_a[WIDTH-1]);
                zero <= (w_final_sum == '0);
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_alu_seq.sv
// Self-checking bench for nibble_serial_alu_seq (WIDTH=32): directed table,
// randomized operations against an arithmetic model, backpressure and reset abort.
module tb_nibble_serial_alu_seq;

    localparam int W   = 32;
    localparam int LAT = W / 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    nibble_serial_alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] e_sum;
        logic         e_cout;
        logic         e_ovf;
        logic         e_zero;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference from plain integer arithmetic: unsigned for sum/carry, signed for overflow.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic msub,
                         output logic [W-1:0] r_sum, output logic r_cout,
                         output logic r_ovf, output logic r_zero);
        longint ua, ub, us, sa, sb, ss;
        ua = longint'({32'd0, ma});
        ub = longint'({32'd0, mb});
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        if (msub) begin
            us     = ua - ub;
            ss     = sa - sb;
            r_cout = (ua >= ub);
        end else begin
            us     = ua + ub;
            ss     = sa + sb;
            r_cout = (us > 64'sh0_FFFF_FFFF);
        end
        r_sum  = us[W-1:0];
        r_ovf  = (ss > 64'sh7FFF_FFFF) || (ss < -64'sh8000_0000);
        r_zero = (r_sum == '0);
    endtask

    // Present one operand pair, wait for the result, check it, then release it.
    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tsub, input logic [W-1:0] e_sum, input logic e_cout,
                          input logic e_ovf, input logic e_zero);
        int cyc;
        @(negedge clk);
        chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        a        = ta;
        b        = tb_;
        sub      = tsub;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 4 * LAT) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, ".latency"}, 64'(cyc), 64'(LAT));
        chk({tag, ".sum"},  64'(sum),  64'(e_sum));
        chk({tag, ".cout"}, 64'(cout), 64'(e_cout));
        chk({tag, ".ovf"},  64'(ovf),  64'(e_ovf));
        chk({tag, ".zero"}, 64'(zero), 64'(e_zero));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, ".release_ovalid"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        vec_t         vecs [8];
        logic [W-1:0] m_sum, held_sum, na, nb;
        logic         m_cout, m_ovf, m_zero, held_c, held_o, held_z;
        int           cyc;

        vecs[0] = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{32'h1234_5678, 32'h0FED_CBA9, 1'b0, 32'h2222_2221, 1'b0, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.in_ready",  64'(in_ready),  64'd1);
        chk("reset.out_valid", 64'(out_valid), 64'd0);
        chk("reset.sum",       64'(sum),       64'd0);
        chk("reset.cout",      64'(cout),      64'd0);
        chk("reset.ovf",       64'(ovf),       64'd0);
        chk("reset.zero",      64'(zero),      64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub,
                   vecs[i].e_sum, vecs[i].e_cout, vecs[i].e_ovf, vecs[i].e_zero);
        end

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            logic         rs;
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
            rs = 1'($urandom_range(0, 1));
            model(ra, rb, rs, m_sum, m_cout, m_ovf, m_zero);
            run_op($sformatf("rnd%0d", i), ra, rb, rs, m_sum, m_cout, m_ovf, m_zero);
        end

        // Backpressure: result held while new operands wait at the input.
        model(32'h0000_0064, 32'h0000_00C8, 1'b1, m_sum, m_cout, m_ovf, m_zero);
        @(negedge clk);
        in_valid = 1'b1;
        a = 32'h0000_0064;
        b = 32'h0000_00C8;
        sub = 1'b1;
        @(posedge clk);
        #1;
        na = 32'hDEAD_0000;
        nb = 32'h0000_BEEF;
        a = na;
        b = nb;
        sub = 1'b0;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 4 * LAT) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("bp.latency", 64'(cyc), 64'(LAT));
        chk("bp.sum", 64'(sum), 64'(m_sum));
        held_sum = sum;
        held_c   = cout;
        held_o   = ovf;
        held_z   = zero;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp.hold%0d.sum", k),  64'(sum),       64'(held_sum));
            chk($sformatf("bp.hold%0d.flags", k), 64'({cout, ovf, zero}),
                64'({held_c, held_o, held_z}));
            chk($sformatf("bp.hold%0d.in_ready", k),  64'(in_ready),  64'd0);
            chk($sformatf("bp.hold%0d.out_valid", k), 64'(out_valid), 64'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp.idle.in_ready",  64'(in_ready),  64'd1);
        chk("bp.idle.out_valid", 64'(out_valid), 64'd0);
        chk("bp.idle.sum",       64'(sum),       64'(held_sum));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp.accept.in_ready", 64'(in_ready), 64'd0);
        model(na, nb, 1'b0, m_sum, m_cout, m_ovf, m_zero);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 4 * LAT) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("bp.new.latency", 64'(cyc), 64'(LAT));
        chk("bp.new.sum",     64'(sum), 64'(m_sum));
        chk("bp.new.flags",   64'({cout, ovf, zero}), 64'({m_cout, m_ovf, m_zero}));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset abort while the fourth nibble is in flight.
        @(negedge clk);
        in_valid = 1'b1;
        a = 32'h1234_5678;
        b = 32'h1111_1111;
        sub = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort.in_ready",  64'(in_ready),  64'd1);
        chk("abort.out_valid", 64'(out_valid), 64'd0);
        chk("abort.sum",       64'(sum),       64'd0);
        chk("abort.flags",     64'({cout, ovf, zero}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("abort.fresh", 32'h0000_0002, 32'h0000_0003, 1'b0,
               32'h0000_0005, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
